// File: rtl/page_table_walker_if.sv
// Walker-side bundle: miss request, PTE memory read port, TLB fill and fault reporting.
// master = walker, slave = TLB/memory side.
interface page_table_walker_if #(
  parameter int unsigned VA_WIDTH  = 32,
  parameter int unsigned PA_WIDTH  = 32,
  parameter int unsigned MEM_WIDTH = 32
);
  logic [PA_WIDTH-1:0]  i_ptbr;
  logic                 i_req_valid;
  logic [VA_WIDTH-1:0]  i_req_vaddr;
  logic                 o_req_ready;
  logic                 i_flush;
  logic                 o_mem_req;
  logic [PA_WIDTH-1:0]  o_mem_addr;
  logic                 i_mem_valid;
  logic [MEM_WIDTH-1:0] i_mem_data;
  logic                 o_fill_enable;
  logic [VA_WIDTH-1:0]  o_fill_vaddr;
  logic [PA_WIDTH-1:0]  o_fill_paddr;
  logic                 o_fault;
  logic [VA_WIDTH-1:0]  o_fault_vaddr;
  logic                 o_busy;

  modport master (
    input  i_ptbr, i_req_valid, i_req_vaddr, i_flush, i_mem_valid, i_mem_data,
    output o_req_ready, o_mem_req, o_mem_addr, o_fill_enable, o_fill_vaddr,
           o_fill_paddr, o_fault, o_fault_vaddr, o_busy
  );

  modport slave (
    output i_ptbr, i_req_valid, i_req_vaddr, i_flush, i_mem_valid, i_mem_data,
    input  o_req_ready, o_mem_req, o_mem_addr, o_fill_enable, o_fill_vaddr,
           o_fill_paddr, o_fault, o_fault_vaddr, o_busy
  );
endinterface

// File: rtl/page_table_walker.sv
// Two-level page table walker: reads L1 then L0 PTE for a TLB miss and emits a
// one-cycle fill strobe or a fault pulse. All outputs are registered.
module page_table_walker #(
  parameter int unsigned PAGE_BITS = 12,
  parameter int unsigned VA_WIDTH  = 32,
  parameter int unsigned PA_WIDTH  = 32,
  parameter int unsigned MEM_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  page_table_walker_if.master bus
);
  localparam int unsigned LEVEL_BITS = PAGE_BITS - 2;
  localparam int unsigned PPN_WIDTH  = PA_WIDTH - PAGE_BITS;

  typedef enum logic [2:0] {IDLE, L1, L0, FILL, FAULT} state_t;

  state_t              state;
  logic [VA_WIDTH-1:0] vaddr;

  logic [LEVEL_BITS-1:0] req_vpn1;
  logic [LEVEL_BITS-1:0] vpn0;
  logic [PPN_WIDTH-1:0]  ptbr_ppn;
  logic [PPN_WIDTH-1:0]  pte_ppn;
  logic                  pte_v;
  logic                  unused_ok;

  assign req_vpn1  = bus.i_req_vaddr[VA_WIDTH-1 -: LEVEL_BITS];
  assign vpn0      = vaddr[PAGE_BITS +: LEVEL_BITS];
  assign ptbr_ppn  = bus.i_ptbr[PA_WIDTH-1:PAGE_BITS];
  assign pte_ppn   = bus.i_mem_data[PA_WIDTH-1:PAGE_BITS];
  assign pte_v     = bus.i_mem_data[0];
  // PTE flag bits, PTE bits above the PA and the PTBR page offset carry no meaning here.
  assign unused_ok = ^{bus.i_mem_data, bus.i_ptbr};

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      vaddr             <= '0;
      bus.o_req_ready   <= 1'b1;
      bus.o_busy        <= 1'b0;
      bus.o_mem_req     <= 1'b0;
      bus.o_mem_addr    <= '0;
      bus.o_fill_enable <= 1'b0;
      bus.o_fill_vaddr  <= '0;
      bus.o_fill_paddr  <= '0;
      bus.o_fault       <= 1'b0;
      bus.o_fault_vaddr <= '0;
    end else begin
      bus.o_fill_enable <= 1'b0;
      bus.o_fault       <= 1'b0;
      if (bus.i_flush) begin
        // Abort: any response seen this cycle is dropped along with the walk.
        state           <= IDLE;
        bus.o_mem_req   <= 1'b0;
        bus.o_busy      <= 1'b0;
        bus.o_req_ready <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.i_req_valid) begin
              state           <= L1;
              vaddr           <= bus.i_req_vaddr;
              bus.o_mem_req   <= 1'b1;
              bus.o_mem_addr  <= {ptbr_ppn, req_vpn1, 2'b00};
              bus.o_busy      <= 1'b1;
              bus.o_req_ready <= 1'b0;
            end
          end
          L1: begin
            if (bus.i_mem_valid) begin
              if (!pte_v) begin
                state             <= FAULT;
                bus.o_mem_req     <= 1'b0;
                bus.o_fault       <= 1'b1;
                bus.o_fault_vaddr <= vaddr;
              end else begin
                // Request stays high; the new address is the L0 read.
                state          <= L0;
                bus.o_mem_addr <= {pte_ppn, vpn0, 2'b00};
              end
            end
          end
          L0: begin
            if (bus.i_mem_valid) begin
              bus.o_mem_req <= 1'b0;
              if (!pte_v) begin
                state             <= FAULT;
                bus.o_fault       <= 1'b1;
                bus.o_fault_vaddr <= vaddr;
              end else begin
                state             <= FILL;
                bus.o_fill_enable <= 1'b1;
                bus.o_fill_vaddr  <= vaddr;
                bus.o_fill_paddr  <= {pte_ppn, vaddr[PAGE_BITS-1:0]};
              end
            end
          end
          FILL, FAULT: begin
            state           <= IDLE;
            bus.o_busy      <= 1'b0;
            bus.o_req_ready <= 1'b1;
          end
          default: begin
            state           <= IDLE;
            bus.o_mem_req   <= 1'b0;
            bus.o_busy      <= 1'b0;
            bus.o_req_ready <= 1'b1;
          end
        endcase
      end
    end
  end
endmodule
